// File: rtl/fpga_pkg.sv
// Shared types and helpers for the program output channel logic.
// Holds the default word width, the checker state encoding and ring index arithmetic.
package fpga_pkg;

   localparam int DefaultMemoryElementWidth = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } check_state_e;

   // Advance a ring index by one, wrapping at n.
   function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/channel_ring.sv
// Circular word store with push/pop, occupancy count and a sticky overflow flag.
// When full, a write without a pop overwrites the oldest word instead of stalling.
module channel_ring
   import fpga_pkg::*;
#(
   parameter int Width      = DefaultMemoryElementWidth,
   parameter int NOut       = 100,
   parameter int CountWidth = 8
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  write_valid,
   input  logic [Width-1:0]      write_data,
   input  logic                  read_ready,
   output logic                  read_valid,
   output logic [Width-1:0]      read_data,
   output logic                  pop,
   output logic [CountWidth-1:0] count,
   output logic                  overflow
);

   localparam int PosW = (NOut > 1) ? $clog2(NOut) : 1;

   logic [Width-1:0]      mem_q [NOut];
   logic [PosW-1:0]       read_pos_q, read_pos_d;
   logic [PosW-1:0]       write_pos_q, write_pos_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  full;

   assign read_valid = (count_q != '0);
   assign pop        = read_valid && read_ready;
   assign full       = (count_q == CountWidth'(NOut));
   assign read_data  = mem_q[read_pos_q];
   assign count      = count_q;
   assign overflow   = overflow_q;

   always_comb begin
      read_pos_d  = read_pos_q;
      write_pos_d = write_pos_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      if (write_valid) begin
         write_pos_d = PosW'(inc_mod(32'(write_pos_q), NOut));
      end
      // A write into a full ring with no pop drops the oldest word by moving readPos along.
      if (pop || (write_valid && full)) begin
         read_pos_d = PosW'(inc_mod(32'(read_pos_q), NOut));
      end
      if (write_valid && !pop) begin
         if (full) begin
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (pop && !write_valid) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         read_pos_q  <= '0;
         write_pos_q <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         read_pos_q  <= read_pos_d;
         write_pos_q <= write_pos_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (write_valid) begin
         mem_q[write_pos_q] <= write_data;
      end
   end

endmodule

// File: rtl/out_channel_reader.sv
// Receiving end of the program output channel: buffers words, drains them on a
// valid/ready stream, and optionally checks drained words against an expected table.
module out_channel_reader
   import fpga_pkg::*;
#(
   parameter int MemoryElementWidth = DefaultMemoryElementWidth,
   parameter int NOut               = 100,
   parameter int NExpected          = 8,
   parameter int CountWidth         = 8
) (
   input  logic                          clock,
   input  logic                          resetN,
   input  logic                          writeValid,
   input  logic [MemoryElementWidth-1:0] writeData,
   output logic                          readValid,
   output logic [MemoryElementWidth-1:0] readData,
   input  logic                          readReady,
   input  logic                          expectWrite,
   input  logic [CountWidth-1:0]         expectIndex,
   input  logic [MemoryElementWidth-1:0] expectData,
   input  logic                          start,
   input  logic [CountWidth-1:0]         expectCount,
   output logic [CountWidth-1:0]         count,
   output logic                          overflow,
   output logic                          finished,
   output logic                          success,
   output logic [CountWidth-1:0]         mismatchIndex
);

   localparam int ExpW = (NExpected > 1) ? $clog2(NExpected) : 1;

   logic                          pop;
   logic [MemoryElementWidth-1:0] table_q [NExpected];

   check_state_e          state_q, state_d;
   logic [CountWidth-1:0] check_pos_q, check_pos_d;
   logic [CountWidth-1:0] limit_q, limit_d;
   logic [CountWidth-1:0] mismatch_index_q, mismatch_index_d;
   logic                  mismatch_q, mismatch_d;
   logic                  finished_q, finished_d;
   logic                  success_q, success_d;

   channel_ring #(
      .Width     (MemoryElementWidth),
      .NOut      (NOut),
      .CountWidth(CountWidth)
   ) u_ring (
      .clock      (clock),
      .resetN     (resetN),
      .write_valid(writeValid),
      .write_data (writeData),
      .read_ready (readReady),
      .read_valid (readValid),
      .read_data  (readData),
      .pop        (pop),
      .count      (count),
      .overflow   (overflow)
   );

   always_ff @(posedge clock) begin
      if (expectWrite && (expectIndex < CountWidth'(NExpected))) begin
         table_q[expectIndex[ExpW-1:0]] <= expectData;
      end
   end

   always_comb begin
      state_d          = state_q;
      check_pos_d      = check_pos_q;
      limit_d          = limit_q;
      mismatch_index_d = mismatch_index_q;
      mismatch_d       = mismatch_q;
      finished_d       = finished_q;
      success_d        = success_q;
      if (start) begin
         state_d          = CHECK;
         check_pos_d      = '0;
         mismatch_d       = 1'b0;
         mismatch_index_d = '0;
         finished_d       = 1'b0;
         success_d        = 1'b0;
         limit_d          = (expectCount > CountWidth'(NExpected)) ? CountWidth'(NExpected)
                                                                   : expectCount;
      end else begin
         case (state_q)
            CHECK: begin
               if (check_pos_q == limit_q) begin
                  state_d    = DONE;
                  finished_d = 1'b1;
                  success_d  = !mismatch_q && !overflow;
               end else if (pop) begin
                  if ((readData != table_q[check_pos_q[ExpW-1:0]]) && !mismatch_q) begin
                     mismatch_d       = 1'b1;
                     mismatch_index_d = check_pos_q;
                  end
                  check_pos_d = check_pos_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q          <= IDLE;
         check_pos_q      <= '0;
         limit_q          <= '0;
         mismatch_index_q <= '0;
         mismatch_q       <= 1'b0;
         finished_q       <= 1'b0;
         success_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         check_pos_q      <= check_pos_d;
         limit_q          <= limit_d;
         mismatch_index_q <= mismatch_index_d;
         mismatch_q       <= mismatch_d;
         finished_q       <= finished_d;
         success_q        <= success_d;
      end
   end

   assign finished      = finished_q;
   assign success       = success_q;
   assign mismatchIndex = mismatch_index_q;

endmodule

// File: tb/tb_out_channel_reader.sv
// Directed bench for out_channel_reader with a 4-word ring so wrap and overflow are reachable.
module tb_out_channel_reader;

   localparam int W  = 12;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          resetN;
   logic          writeValid;
   logic [W-1:0]  writeData;
   logic          readValid;
   logic [W-1:0]  readData;
   logic          readReady;
   logic          expectWrite;
   logic [CW-1:0] expectIndex;
   logic [W-1:0]  expectData;
   logic          start;
   logic [CW-1:0] expectCount;
   logic [CW-1:0] count;
   logic          overflow;
   logic          finished;
   logic          success;
   logic [CW-1:0] mismatchIndex;

   int checks   = 0;
   int failures = 0;

   out_channel_reader #(
      .MemoryElementWidth(W),
      .NOut              (4),
      .NExpected         (8),
      .CountWidth        (CW)
   ) dut (
      .clock        (clock),
      .resetN       (resetN),
      .writeValid   (writeValid),
      .writeData    (writeData),
      .readValid    (readValid),
      .readData     (readData),
      .readReady    (readReady),
      .expectWrite  (expectWrite),
      .expectIndex  (expectIndex),
      .expectData   (expectData),
      .start        (start),
      .expectCount  (expectCount),
      .count        (count),
      .overflow     (overflow),
      .finished     (finished),
      .success      (success),
      .mismatchIndex(mismatchIndex)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input int idx, input int val);
      expectWrite = 1'b1;
      expectIndex = CW'(idx);
      expectData  = W'(val);
      tick();
      expectWrite = 1'b0;
   endtask

   task automatic arm(input int n);
      start       = 1'b1;
      expectCount = CW'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic push(input int val);
      writeValid = 1'b1;
      writeData  = W'(val);
      tick();
      writeValid = 1'b0;
   endtask

   task automatic wait_finished();
      for (int i = 0; i < 20; i++) begin
         if (finished) break;
         tick();
      end
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      #3;
      resetN = 1'b1;
      tick();
   endtask

   initial begin
      resetN      = 1'b0;
      writeValid  = 1'b0;
      writeData   = '0;
      readReady   = 1'b0;
      expectWrite = 1'b0;
      expectIndex = '0;
      expectData  = '0;
      start       = 1'b0;
      expectCount = '0;
      #12;
      chk("rst_readValid", readValid, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_finished", finished, 0);
      chk("rst_success", success, 0);
      chk("rst_mismatchIndex", mismatchIndex, 0);
      resetN = 1'b1;
      tick();

      // Single word 5 checked against table[0]=5.
      load(0, 5);
      arm(1);
      readReady = 1'b1;
      chk("t1_empty_valid", readValid, 0);
      push(3 + 2);
      chk("t1_valid", readValid, 1);
      chk("t1_data", readData, 5);
      wait_finished();
      chk("t1_finished", finished, 1);
      chk("t1_success", success, 1);
      chk("t1_mmidx", mismatchIndex, 0);

      // Three words, third one wrong.
      load(0, 1);
      load(1, 2);
      load(2, 3);
      arm(3);
      writeValid = 1'b1;
      writeData  = 12'd1;
      tick();
      writeData = 12'd2;
      tick();
      writeData = 12'd4;
      tick();
      writeValid = 1'b0;
      tick();
      wait_finished();
      chk("t2_finished", finished, 1);
      chk("t2_success", success, 0);
      chk("t2_mmidx", mismatchIndex, 2);

      // Zero-length check completes one cycle after start.
      arm(0);
      chk("t3_cleared", finished, 0);
      tick();
      chk("t3_finished", finished, 1);
      chk("t3_success", success, 1);

      // Overflow: five writes into a 4-deep ring drop the oldest word.
      readReady = 1'b0;
      for (int v = 10; v <= 14; v++) push(v);
      chk("ovf_count", count, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_oldest", readData, 11);
      readReady = 1'b1;
      for (int v = 11; v <= 14; v++) begin
         chk("ovf_drain", readData, v);
         tick();
      end
      chk("ovf_empty", readValid, 0);
      tick();
      chk("ovf_empty_count", count, 0);

      arm(0);
      tick();
      chk("t3b_finished", finished, 1);
      chk("t3b_success", success, 0);

      // Full ring with write and pop in the same cycle loses nothing.
      do_reset();
      chk("rst2_overflow", overflow, 0);
      readReady = 1'b0;
      for (int v = 10; v <= 13; v++) push(v);
      chk("full_count", count, 4);
      writeValid = 1'b1;
      writeData  = 12'd20;
      readReady  = 1'b1;
      chk("full_popdata", readData, 10);
      tick();
      writeValid = 1'b0;
      readReady  = 1'b0;
      chk("full_count_after", count, 4);
      chk("full_overflow", overflow, 0);
      chk("full_next", readData, 11);
      readReady = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("full_drained", readValid, 0);

      // Reset in the middle of a check, then a clean check from index 0.
      load(8, 7);
      arm(3);
      push(1);
      tick();
      readReady = 1'b0;
      push(2);
      #2;
      resetN = 1'b0;
      #1;
      chk("mid_count", count, 0);
      chk("mid_valid", readValid, 0);
      chk("mid_finished", finished, 0);
      chk("mid_success", success, 0);
      chk("mid_mmidx", mismatchIndex, 0);
      chk("mid_overflow", overflow, 0);
      #2;
      resetN = 1'b1;
      tick();
      arm(3);
      readReady  = 1'b1;
      writeValid = 1'b1;
      writeData  = 12'd1;
      tick();
      writeData = 12'd2;
      tick();
      writeData = 12'd3;
      tick();
      writeValid = 1'b0;
      tick();
      wait_finished();
      chk("re_finished", finished, 1);
      chk("re_success", success, 1);
      chk("re_mmidx", mismatchIndex, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
